gate_bist_exerciser: RTL and testbench
======================================

Name: gate_bist_exerciser

Overview:
Hardware counterpart to the team's gate stimulus benches. It drives every input combination into a combinational gate under test (DUT), waits a programmable settle time, and samples the DUT output. Each sample is compared against a parameterised truth table. Errors are counted and the first failing vector is reported. It sits beside any module in gates/ as an on-chip self-test harness.

Parameters:
N_INPUTS, 2, DUT input count; vectors 0 .. 2^N_INPUTS-1; legal range 1..6
TRUTH_TABLE, 4'b1000, expected DUT output; bit k = expected output for input vector k; width 2^N_INPUTS; default is 2-input AND
SETTLE_CYCLES, 1, cycles each vector is held before sampling; must be >= 1
ERR_W, 4, error counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  run request; honoured only in IDLE or DONE
dut_out  input  1  DUT output
dut_in  output  N_INPUTS  vector driven to DUT
busy  output  1  high in SETTLE/SAMPLE
done  output  1  high in DONE, sticky until next start or reset
pass  output  1  done && err_count==0
err_count  output  ERR_W  mismatches this run, saturating at all-ones
fail_valid  output  1  at least one mismatch recorded this run
fail_vec  output  N_INPUTS  first failing vector; valid when fail_valid

Behaviour:
- Reset (async, any state): state=IDLE; dut_in=0; busy=0; done=0; pass=0; err_count=0; fail_valid=0; fail_vec=0; settle counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE with start=1 (edge k): next state SETTLE. dut_in=0, err_count=0, fail_valid=0, fail_vec=0, done=0, settle counter=SETTLE_CYCLES-1.
- SETTLE: hold dut_in. If counter==0, go to SAMPLE; else decrement.
- SAMPLE (one cycle): compare dut_out with TRUTH_TABLE[dut_in].
  - On mismatch: err_count += 1, saturating.
  - On mismatch with fail_valid==0: fail_vec=dut_in, fail_valid=1.
  - If dut_in == 2^N_INPUTS-1: go to DONE and hold dut_in.
  - Otherwise: dut_in += 1, counter reloads to SETTLE_CYCLES-1, go to SETTLE.
- Per-vector cost: SETTLE_CYCLES+1 cycles. Run length from start edge to done=1: 2^N_INPUTS*(SETTLE_CYCLES+1) cycles. Default is 8.
- start is ignored while busy. start held high in DONE restarts immediately.
- dut_out is sampled only in SAMPLE; its value in other states is don't-care.
- pass is combinational from done and err_count. It is 0 whenever done=0.
- Reset mid-run aborts at once. No partial result is retained.
- dut_in wraps never. The last vector is held through DONE.

Optional Feature:
Macro GATE_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE. err_count=1, fail_vec = that vector, dut_in holds the failing vector.
- Undefined: all vectors are always exercised and err_count counts every mismatch.

Test Plan:
- Default params, dut_out = dut_in[0] & dut_in[1], start pulse -> done=1 exactly 8 cycles after start edge; pass=1, err_count=0, fail_valid=0; dut_in sequence 0,1,2,3, each held 2 cycles.
- Default params, dut_out tied 0 -> done after 8 cycles; err_count=1, fail_vec=3, pass=0.
- Default params, dut_out = OR of inputs -> err_count=2, fail_vec=1. With GATE_BIST_STOP_ON_FAIL_EN: done after 4 cycles, err_count=1, fail_vec=1, dut_in=1.
- SETTLE_CYCLES=3, N_INPUTS=3, TRUTH_TABLE=8'b1001_0110, DUT = 3-input XOR -> done after 32 cycles, pass=1. Additionally, a start pulse mid-run is ignored.
- ERR_W=2, N_INPUTS=3, TRUTH_TABLE=0, dut_out tied 1 -> err_count saturates at 3, fail_vec=0.
- Assert rst in cycle 3 of a run -> all outputs read 0 asynchronously, state IDLE. A fresh start then completes normally with pass=1 for the AND DUT.

Source files
------------

// File: rtl/gate_bist_exerciser_if.sv
// gate_bist_exerciser_if
// Bundles the run control, the DUT stimulus/response pair and the result
// outputs of gate_bist_exerciser.
//   slave  : the exerciser itself (takes start/dut_out, drives everything else)
//   master : whoever controls a run and provides the gate under test
// Signals:
//   start      run request
//   dut_out    output of the gate under test
//   dut_in     vector driven into the gate under test (N_INPUTS bits)
//   busy       run in progress
//   done       run finished, sticky until the next start or reset
//   pass       done with no mismatches
//   err_count  mismatch count, saturating (ERR_W bits)
//   fail_valid at least one mismatch recorded this run
//   fail_vec   first failing vector (N_INPUTS bits)
interface gate_bist_exerciser_if #(
    parameter int N_INPUTS = 2,
    parameter int ERR_W    = 4
);
    logic                start;
    logic                dut_out;
    logic [N_INPUTS-1:0] dut_in;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_count;
    logic                fail_valid;
    logic [N_INPUTS-1:0] fail_vec;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/gate_bist_exerciser.sv
// gate_bist_exerciser
// On-chip self-test harness for a combinational gate. After start it walks
// every input vector 0 .. 2^N_INPUTS-1 into the gate, holds each vector for
// SETTLE_CYCLES cycles, then samples the gate output for one cycle and
// compares it with TRUTH_TABLE[vector]. Mismatches are counted (saturating)
// and the first failing vector is captured.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, aborts any run
//   bus  gate_bist_exerciser_if.slave (start, dut_out in; dut_in, busy,
//        done, pass, err_count, fail_valid, fail_vec out)
// Build option:
//   GATE_BIST_STOP_ON_FAIL_EN - when defined the run ends at the first
//   mismatch, leaving the failing vector on dut_in.
module gate_bist_exerciser #(
    parameter int                          N_INPUTS      = 2,
    parameter logic [(1<<N_INPUTS)-1:0]    TRUTH_TABLE   = 4'b1000,
    parameter int                          SETTLE_CYCLES = 1,
    parameter int                          ERR_W         = 4
) (
    input  logic clk,
    input  logic rst,
    gate_bist_exerciser_if.slave bus
);
    // Counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] LAST_VEC   = '1;
    localparam logic [ERR_W-1:0]    ERR_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [N_INPUTS-1:0] vec_reg, vec_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ERR_W-1:0]    err_reg, err_next;
    logic                fv_reg, fv_next;
    logic [N_INPUTS-1:0] fvec_reg, fvec_next;
    logic                mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            vec_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= '0;
            fv_reg    <= 1'b0;
            fvec_reg  <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            fv_reg    <= fv_next;
            fvec_reg  <= fvec_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        fv_next    = fv_reg;
        fvec_next  = fvec_reg;
        // Only meaningful in SAMPLE; dut_out is don't-care elsewhere.
        mismatch   = (bus.dut_out != TRUTH_TABLE[vec_reg]);

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next = ST_SETTLE;
                    vec_next   = '0;
                    cnt_next   = CNT_RELOAD;
                    err_next   = '0;
                    fv_next    = 1'b0;
                    fvec_next  = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_reg != ERR_MAX) begin
                        err_next = err_reg + 1'b1;
                    end
                    if (!fv_reg) begin
                        fv_next   = 1'b1;
                        fvec_next = vec_reg;
                    end
                end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                if (mismatch || (vec_reg == LAST_VEC)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    vec_next   = vec_reg + 1'b1;
                    cnt_next   = CNT_RELOAD;
                end
`else
                if (vec_reg == LAST_VEC) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    vec_next   = vec_reg + 1'b1;
                    cnt_next   = CNT_RELOAD;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Status decodes straight from registered state so reset clears them
    // without waiting for a clock.
    assign bus.dut_in     = vec_reg;
    assign bus.busy       = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.pass       = (state_reg == ST_DONE) && (err_reg == '0);
    assign bus.err_count  = err_reg;
    assign bus.fail_valid = fv_reg;
    assign bus.fail_vec   = fvec_reg;
endmodule

// File: tb/tb_gate_bist_exerciser.sv
`timescale 1ns/1ps
// Scoreboard bench for gate_bist_exerciser. Three instances cover the
// default 2-input AND, a 3-input XOR with SETTLE_CYCLES=3, and a narrow
// error counter with an all-zero table. Stimulus pushes expected run
// results; per-instance monitors pop them when done rises.
module tb_gate_bist_exerciser;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mode_a = 0;   // 0: AND gate, 1: tied 0, 2: OR gate

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_bist_exerciser_if #(.N_INPUTS(2), .ERR_W(4)) ia ();
    gate_bist_exerciser_if #(.N_INPUTS(3), .ERR_W(4)) ib ();
    gate_bist_exerciser_if #(.N_INPUTS(3), .ERR_W(2)) ic ();

    gate_bist_exerciser u_a (.clk(clk), .rst(rst), .bus(ia));
    gate_bist_exerciser #(.N_INPUTS(3), .TRUTH_TABLE(8'b1001_0110),
                          .SETTLE_CYCLES(3), .ERR_W(4))
        u_b (.clk(clk), .rst(rst), .bus(ib));
    gate_bist_exerciser #(.N_INPUTS(3), .TRUTH_TABLE(8'b0000_0000),
                          .SETTLE_CYCLES(1), .ERR_W(2))
        u_c (.clk(clk), .rst(rst), .bus(ic));

    assign ia.dut_out = (mode_a == 0) ? (ia.dut_in[0] & ia.dut_in[1]) :
                        (mode_a == 1) ? 1'b0 : (ia.dut_in[0] | ia.dut_in[1]);
    assign ib.dut_out = ^ib.dut_in;
    assign ic.dut_out = 1'b1;

    typedef struct {
        string name;
        int    start_cyc;
        int    cycles;
        int    err;
        int    fv;
        int    fvec;
        int    last_in;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   trace_a[$];   // expected dut_in while busy, one entry per cycle

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_run(input exp_t e, input int now, input int err,
                             input int fv, input int fvec, input int ps,
                             input int din);
        $display("run %s: cycles=%0d err=%0d fail_valid=%0d fail_vec=%0d pass=%0d dut_in=%0d",
                 e.name, now - e.start_cyc, err, fv, fvec, ps, din);
        chk({e.name, ".cycles"},     now - e.start_cyc, e.cycles);
        chk({e.name, ".err_count"},  err, e.err);
        chk({e.name, ".fail_valid"}, fv, e.fv);
        chk({e.name, ".fail_vec"},   fvec, e.fvec);
        chk({e.name, ".pass"},       ps, (e.err == 0) ? 1 : 0);
        chk({e.name, ".dut_in"},     din, e.last_in);
    endtask

    // Monitors: compare when done rises; flag any completion nobody expected.
    logic done_a_q = 1'b0, done_b_q = 1'b0, done_c_q = 1'b0;
    always @(negedge clk) begin
        if (ia.busy && trace_a.size() > 0) begin
            int e_in;
            e_in = trace_a.pop_front();
            chk("a.trace_dut_in", int'(ia.dut_in), e_in);
        end
        if (ia.done && !done_a_q) begin
            if (qa.size() == 0) chk("a.unexpected_done", 1, 0);
            else check_run(qa.pop_front(), cyc, int'(ia.err_count), int'(ia.fail_valid),
                           int'(ia.fail_vec), int'(ia.pass), int'(ia.dut_in));
        end
        if (ib.done && !done_b_q) begin
            if (qb.size() == 0) chk("b.unexpected_done", 1, 0);
            else check_run(qb.pop_front(), cyc, int'(ib.err_count), int'(ib.fail_valid),
                           int'(ib.fail_vec), int'(ib.pass), int'(ib.dut_in));
        end
        if (ic.done && !done_c_q) begin
            if (qc.size() == 0) chk("c.unexpected_done", 1, 0);
            else check_run(qc.pop_front(), cyc, int'(ic.err_count), int'(ic.fail_valid),
                           int'(ic.fail_vec), int'(ic.pass), int'(ic.dut_in));
        end
        done_a_q <= ia.done;
        done_b_q <= ib.done;
        done_c_q <= ic.done;
    end

    // One-cycle start pulse on the selected instance; returns the cycle
    // number right after the start edge.
    task automatic pulse_start(input int which, output int s);
        @(negedge clk);
        case (which)
            0: ia.start = 1'b1;
            1: ib.start = 1'b1;
            default: ic.start = 1'b1;
        endcase
        @(posedge clk);
        #1;
        s = cyc;
        ia.start = 1'b0;
        ib.start = 1'b0;
        ic.start = 1'b0;
    endtask

    task automatic run(input int which, input string name, input int cycles,
                       input int err, input int fv, input int fvec, input int last_in);
        exp_t e;
        int   s;
        pulse_start(which, s);
        e.name = name; e.start_cyc = s; e.cycles = cycles; e.err = err;
        e.fv = fv; e.fvec = fvec; e.last_in = last_in;
        case (which)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (qa.size() + qb.size() + qc.size()) > 0; i++)
            @(negedge clk);
        if ((qa.size() + qb.size() + qc.size()) > 0) begin
            chk("timeout_waiting_done", qa.size() + qb.size() + qc.size(), 0);
            qa.delete(); qb.delete(); qc.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_a_zero(input string tag);
        chk({tag, ".dut_in"},     int'(ia.dut_in), 0);
        chk({tag, ".busy"},       int'(ia.busy), 0);
        chk({tag, ".done"},       int'(ia.done), 0);
        chk({tag, ".pass"},       int'(ia.pass), 0);
        chk({tag, ".err_count"},  int'(ia.err_count), 0);
        chk({tag, ".fail_valid"}, int'(ia.fail_valid), 0);
        chk({tag, ".fail_vec"},   int'(ia.fail_vec), 0);
        $display("%s: outputs checked against zero", tag);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        repeat (3) @(negedge clk);
        check_a_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // AND gate, default build: four vectors each held two cycles.
        mode_a = 0;
        foreach (trace_a[i]) trace_a.delete(i);
        for (int v = 0; v < 4; v++) begin
            trace_a.push_back(v);
            trace_a.push_back(v);
        end
        run(0, "and_pass", 8, 0, 0, 0, 3);
        drain();

        // Output stuck at 0: only vector 3 disagrees.
        mode_a = 1;
        run(0, "stuck0", 8, 1, 1, 3, 3);
        drain();

        // OR gate against the AND table: vectors 1 and 2 disagree.
        mode_a = 2;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        run(0, "or_gate", 4, 1, 1, 1, 1);
`else
        run(0, "or_gate", 8, 2, 1, 1, 3);
`endif
        drain();

        // 3-input XOR, SETTLE_CYCLES=3; a start pulse mid-run must be ignored.
        pulse_start(1, s);
        begin
            exp_t e;
            e.name = "xor3"; e.start_cyc = s; e.cycles = 32; e.err = 0;
            e.fv = 0; e.fvec = 0; e.last_in = 7;
            qb.push_back(e);
        end
        repeat (10) @(posedge clk);
        @(negedge clk); ib.start = 1'b1;
        @(negedge clk); ib.start = 1'b0;
        drain();

        // All-zero table with output tied 1: narrow counter saturates.
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        run(2, "saturate", 2, 1, 1, 0, 0);
`else
        run(2, "saturate", 16, 3, 1, 0, 7);
`endif
        drain();

        // Reset three cycles into a run aborts asynchronously.
        mode_a = 0;
        pulse_start(0, s);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_a_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(0, "after_abort", 8, 0, 0, 0, 3);
        drain();

        chk("trace_leftover", trace_a.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
